// File: rtl/spart_pkg.sv
// Shared definitions for the SPART self-test driver: bus addresses, the
// driver state encoding, default baud divisors and pattern helpers.
package spart_pkg;

    // Processor-side register map of the SPART
    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    // Default divisors for br_cfg = 00/01/10/11
    localparam logic [15:0] DIV_DEFAULT0 = 16'd1301;
    localparam logic [15:0] DIV_DEFAULT1 = 16'd650;
    localparam logic [15:0] DIV_DEFAULT2 = 16'd325;
    localparam logic [15:0] DIV_DEFAULT3 = 16'd162;

    // Driver states; the encoding is visible on state_value
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_LOW  = 4'd1,
        LOAD_HIGH = 4'd2,
        WAIT_TBR  = 4'd3,
        WRITE     = 4'd4,
        WAIT_RDA  = 4'd5,
        READ      = 4'd6,
        CHECK     = 4'd7,
        DONE      = 4'd8
    } state_e;

    // Maximal-length 8-bit LFSR step (taps 8,6,5,4); never produces 0 from a non-zero value
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // Next pattern byte: increment (wrapping) or LFSR step
    function automatic logic [7:0] pattern_next(input logic [7:0] cur, input logic lfsr_mode);
        logic [7:0] nxt;
        if (lfsr_mode) begin
            nxt = lfsr_next(cur);
        end else begin
            nxt = cur + 8'd1;
        end
        return nxt;
    endfunction

    // First pattern byte: the LFSR would lock up at zero, so substitute 1
    function automatic logic [7:0] pattern_seed(input logic [7:0] seed, input logic lfsr_mode);
        logic [7:0] first;
        if (lfsr_mode && (seed == 8'h00)) begin
            first = 8'h01;
        end else begin
            first = seed;
        end
        return first;
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/spart_pattern_gen.sv
// Pattern byte register for the SPART self-test: load with a seed and a mode
// (incrementing or LFSR), then advance one step per byte.
module spart_pattern_gen
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       mode_i,
    input  logic       advance_i,
    output logic [7:0] pattern_o
);

    logic [7:0] pat_q, pat_d;
    logic       mode_q, mode_d;

    // Next pattern value: load has priority over advance
    always_comb begin
        pat_d  = pat_q;
        mode_d = mode_q;
        if (load_i) begin
            pat_d  = pattern_seed(seed_i, mode_i);
            mode_d = mode_i;
        end else if (advance_i) begin
            pat_d  = pattern_next(pat_q, mode_q);
        end else begin
            pat_d  = pat_q;
        end
    end

    // Pattern and mode registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= 8'h00;
            mode_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            mode_q <= mode_d;
        end
    end

    assign pattern_o = pat_q;

endmodule

// File: rtl/spart_bist_driver.sv
// SPART self-test driver: programs the baud divisor, then writes a burst of
// pattern bytes, reads each echo back and tallies passes, mismatches and
// timeouts. All bus outputs are registered and decoded from the next state,
// so each strobe lines up exactly with its state cycle.
module spart_bist_driver
    import spart_pkg::*;
#(
    parameter int          BURST_LEN = 16,
    parameter logic [7:0]  SEED      = 8'hAA,
    parameter int          TIMEOUT   = 65535,
    parameter logic [15:0] DIV0      = DIV_DEFAULT0,
    parameter logic [15:0] DIV1      = DIV_DEFAULT1,
    parameter logic [15:0] DIV2      = DIV_DEFAULT2,
    parameter logic [15:0] DIV3      = DIV_DEFAULT3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  br_cfg,
    input  logic        mode,
    input  logic        rda,
    input  logic        tbr,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] err_count,
    output logic        timeout_seen,
    output logic [3:0]  state_value
);

    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  rx_q, rx_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] err_q, err_d;
    logic        ts_q, ts_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        drive_q, drive_d;

    logic        accept_s;
    logic        byte_end_s;
    logic [15:0] div_sel_s;
    logic [7:0]  pattern_s;

    spart_pattern_gen u_pattern (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept_s),
        .seed_i    (SEED),
        .mode_i    (mode),
        .advance_i (byte_end_s),
        .pattern_o (pattern_s)
    );

    // Divisor chosen by the baud select input
    always_comb begin
        div_sel_s = DIV0;
        case (br_cfg)
            2'b00:   div_sel_s = DIV0;
            2'b01:   div_sel_s = DIV1;
            2'b10:   div_sel_s = DIV2;
            2'b11:   div_sel_s = DIV3;
            default: div_sel_s = DIV0;
        endcase
    end

    // Sequencer: next state, counters, capture and result tallies
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        tmo_d      = 16'd0;
        rx_d       = rx_q;
        pass_d     = pass_q;
        err_d      = err_q;
        ts_d       = ts_q;
        accept_s   = 1'b0;
        byte_end_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_d  = LOAD_LOW;
                    div_d    = div_sel_s;
                    idx_d    = 16'd0;
                    pass_d   = 16'd0;
                    err_d    = 16'd0;
                    ts_d     = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOAD_LOW:  state_d = LOAD_HIGH;
            LOAD_HIGH: state_d = WAIT_TBR;
            WAIT_TBR: begin
                if (tbr) begin
                    state_d = WRITE;
                end else if (tmo_q == TMO_LAST) begin
                    // Abandon the byte without writing it
                    byte_end_s = 1'b1;
                    err_d      = sat_inc16(err_q);
                    ts_d       = 1'b1;
                end else begin
                    tmo_d      = tmo_q + 16'd1;
                end
            end
            WRITE: state_d = WAIT_RDA;
            WAIT_RDA: begin
                if (rda) begin
                    state_d = READ;
                end else if (tmo_q == TMO_LAST) begin
                    byte_end_s = 1'b1;
                    err_d      = sat_inc16(err_q);
                    ts_d       = 1'b1;
                end else begin
                    tmo_d      = tmo_q + 16'd1;
                end
            end
            READ: begin
                rx_d    = databus;
                state_d = CHECK;
            end
            CHECK: begin
                byte_end_s = 1'b1;
                if (rx_q == pattern_s) begin
                    pass_d = sat_inc16(pass_q);
                end else begin
                    err_d  = sat_inc16(err_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Common byte completion for CHECK and timeouts
        if (byte_end_s) begin
            idx_d = idx_q + 16'd1;
            if (idx_q >= LAST_IDX) begin
                state_d = DONE;
            end else begin
                state_d = WAIT_TBR;
            end
        end else begin
            idx_d = idx_d;
        end
    end

    // Output decode from the next state so registered outputs align with it
    always_comb begin
        iocs_d  = 1'b0;
        iorw_d  = 1'b1;
        addr_d  = ADDR_DATA;
        wdata_d = 8'h00;
        drive_d = 1'b0;
        case (state_d)
            LOAD_LOW: begin
                iocs_d  = 1'b1;
                iorw_d  = 1'b0;
                addr_d  = ADDR_DB_LO;
                wdata_d = div_d[7:0];
                drive_d = 1'b1;
            end
            LOAD_HIGH: begin
                iocs_d  = 1'b1;
                iorw_d  = 1'b0;
                addr_d  = ADDR_DB_HI;
                wdata_d = div_d[15:8];
                drive_d = 1'b1;
            end
            WRITE: begin
                iocs_d  = 1'b1;
                iorw_d  = 1'b0;
                addr_d  = ADDR_DATA;
                wdata_d = pattern_s;
                drive_d = 1'b1;
            end
            READ: begin
                iocs_d  = 1'b1;
                iorw_d  = 1'b1;
                addr_d  = ADDR_DATA;
            end
            default: begin
                iocs_d  = 1'b0;
                iorw_d  = 1'b1;
                addr_d  = ADDR_DATA;
            end
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
        if (state_d == DONE) begin
            done_d = 1'b1;
        end else if (accept_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= 16'd0;
            idx_q   <= 16'd0;
            tmo_q   <= 16'd0;
            rx_q    <= 8'h00;
            pass_q  <= 16'd0;
            err_q   <= 16'd0;
            ts_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            iocs_q  <= 1'b0;
            iorw_q  <= 1'b1;
            addr_q  <= ADDR_DATA;
            wdata_q <= 8'h00;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            rx_q    <= rx_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ts_q    <= ts_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            iocs_q  <= iocs_d;
            iorw_q  <= iorw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drive_q <= drive_d;
        end
    end

    assign databus      = drive_q ? wdata_q : 8'hzz;
    assign iocs         = iocs_q;
    assign iorw         = iorw_q;
    assign ioaddr       = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass_count   = pass_q;
    assign err_count    = err_q;
    assign timeout_seen = ts_q;
    assign state_value  = state_q;

endmodule

// File: tb/tb_spart_bist_driver.sv
// Bench for spart_bist_driver: a loopback SPART model echoes each written
// byte; a negedge compare process checks bus traffic, timing and final
// tallies against a transaction-level model; directed runs pin key values.
module tb_spart_bist_driver;

    localparam int BL  = 4;
    localparam int TMO = 20;
    localparam logic [7:0] SEED_V = 8'hAA;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] br_cfg;
    logic       mode;
    logic       tbr;
    logic       rda_en;
    int         corrupt_idx;

    wire        rda;
    wire        iocs;
    wire        iorw;
    wire [1:0]  ioaddr;
    wire [7:0]  databus;
    wire        busy;
    wire        done;
    wire [15:0] pass_count;
    wire [15:0] err_count;
    wire        timeout_seen;
    wire [3:0]  state_value;

    int vectors = 0;
    int fails   = 0;

    // Loopback SPART model
    logic [7:0] spq[$];
    int         spq_n  = 0;
    logic [7:0] echo_r = 8'h00;
    assign rda     = rda_en && (spq_n != 0);
    assign databus = (iocs && iorw) ? echo_r : 8'hzz;

    // Run model and logs
    logic [7:0]  exp_bytes [BL];
    logic [7:0]  wr_log    [BL];
    logic [15:0] run_div;
    logic        run_rda;
    int          run_corrupt;
    int          wr_idx, reads, mpass, cyc, last_wr_cyc, div_wr_cnt;
    logic [7:0]  div_lo_log, div_hi_log;
    logic        prev_busy, prev_done, prev_iocs, run_active;
    logic [1:0]  prev_addr;

    // Standalone pattern generator
    logic       pg_load, pg_mode, pg_adv;
    logic [7:0] pg_seed;
    wire  [7:0] pg_out;

    spart_bist_driver #(.BURST_LEN(BL), .SEED(SEED_V), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .br_cfg(br_cfg), .mode(mode),
        .rda(rda), .tbr(tbr), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .busy(busy), .done(done), .pass_count(pass_count),
        .err_count(err_count), .timeout_seen(timeout_seen), .state_value(state_value)
    );

    spart_pattern_gen pg (
        .clk(clk), .rst(rst), .load_i(pg_load), .seed_i(pg_seed),
        .mode_i(pg_mode), .advance_i(pg_adv), .pattern_o(pg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_next(input logic [7:0] c, input logic m);
        if (!m) return c + 8'd1;
        return {c[6:0], ^(c & 8'b1011_1000)};
    endfunction

    function automatic logic [7:0] m_seed(input logic [7:0] s, input logic m);
        if (m && s == 8'h00) return 8'h01;
        return s;
    endfunction

    function automatic logic [15:0] m_div(input logic [1:0] cfg);
        case (cfg)
            2'd0: return 16'd1301;
            2'd1: return 16'd650;
            2'd2: return 16'd325;
            default: return 16'd162;
        endcase
    endfunction

    // Compare process: bus traffic, timing and end-of-run tallies
    always @(negedge clk) begin
        logic [7:0] cur;
        cyc++;
        if (rst) begin
            prev_busy = 1'b0; prev_done = 1'b0; prev_iocs = 1'b0;
            prev_addr = 2'b00; run_active = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                spq.delete(); spq_n = 0;
                cur = m_seed(SEED_V, mode);
                for (int i = 0; i < BL; i++) begin
                    exp_bytes[i] = cur;
                    cur = m_next(cur, mode);
                end
                run_div = m_div(br_cfg); run_rda = rda_en; run_corrupt = corrupt_idx;
                wr_idx = 0; reads = 0; mpass = 0; last_wr_cyc = -1; div_wr_cnt = 0;
                run_active = 1'b1;
            end
            if (iocs && !iorw) begin
                case (ioaddr)
                    2'b10: begin chk("div_lo", databus, run_div[7:0]); div_lo_log = databus; div_wr_cnt++; end
                    2'b11: begin chk("div_hi", databus, run_div[15:8]); div_hi_log = databus; div_wr_cnt++; end
                    2'b00: begin
                        if (wr_idx < BL) begin
                            chk("data_byte", databus, exp_bytes[wr_idx]);
                            wr_log[wr_idx] = databus;
                        end else begin
                            chk("extra_data_write", wr_idx, BL - 1);
                        end
                        if (last_wr_cyc >= 0) chk("byte_spacing", cyc - last_wr_cyc, run_rda ? 5 : TMO + 2);
                        last_wr_cyc = cyc;
                        spq.push_back(databus ^ ((wr_idx == run_corrupt) ? 8'h01 : 8'h00));
                        spq_n = spq.size();
                        wr_idx++;
                    end
                    default: chk("write_addr", ioaddr, 2'b00);
                endcase
            end
            if (iocs && iorw) begin
                if (spq_n > 0) begin
                    echo_r = spq.pop_front();
                    spq_n = spq.size();
                    reads++;
                    if (wr_idx > 0 && echo_r == exp_bytes[wr_idx-1]) mpass++;
                end else begin
                    chk("read_without_echo", spq_n, 1);
                end
            end
            if (iocs && prev_iocs) chk("strobe_pair", {prev_addr, ioaddr}, 4'b1011);
            if (run_active && !done) chk("pass_le_model", (pass_count <= mpass) ? 1 : 0, 1);
            if (done && !prev_done && run_active) begin
                chk("end_pass", pass_count, mpass);
                chk("end_err", err_count, BL - mpass);
                chk("end_timeout_seen", timeout_seen, (reads < BL) ? 1 : 0);
                chk("end_writes", wr_idx, BL);
                chk("end_busy", busy, 0);
                chk("done_latency", cyc - last_wr_cyc, run_rda ? 4 : TMO + 1);
                run_active = 1'b0;
            end
            prev_busy = busy; prev_done = done; prev_iocs = iocs; prev_addr = ioaddr;
        end
    end

    task automatic run_start(input logic [1:0] cfg, input logic m, input int cor, input logic ren);
        @(negedge clk);
        br_cfg = cfg; mode = m; corrupt_idx = cor; rda_en = ren; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_low_at_n1", state_value, 4'd1);
        @(negedge clk);
        chk("load_high_at_n2", state_value, 4'd2);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        chk("done_within_budget", done, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_iocs"}, iocs, 1'b0);
        chk({tag, "_iorw"}, iorw, 1'b1);
        chk({tag, "_ioaddr"}, ioaddr, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass"}, pass_count, 16'd0);
        chk({tag, "_err"}, err_count, 16'd0);
        chk({tag, "_tseen"}, timeout_seen, 1'b0);
        chk({tag, "_state"}, state_value, 4'd0);
    endtask

    initial begin
        logic [7:0] cur;
        logic       seen [256];
        int         distinct;
        rst = 1'b1; start = 1'b0; br_cfg = 2'b00; mode = 1'b0; tbr = 1'b1;
        rda_en = 1'b1; corrupt_idx = -1;
        pg_load = 1'b0; pg_mode = 1'b0; pg_adv = 1'b0; pg_seed = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Run A: br_cfg=10, incrementing; start in the DONE cycle is ignored
        run_start(2'b10, 1'b0, -1, 1'b1);
        for (int i = 0; i < 200 && state_value != 4'd8; i++) @(negedge clk);
        chk("reach_done_state", state_value, 4'd8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", state_value, 4'd0);
        @(negedge clk);
        chk("still_idle", state_value, 4'd0);
        chk("A_pass", pass_count, 16'd4);
        chk("A_err", err_count, 16'd0);
        chk("A_done", done, 1'b1);
        chk("A_div_lo", div_lo_log, 8'h45);
        chk("A_div_hi", div_hi_log, 8'h01);
        chk("A_byte0", wr_log[0], 8'hAA);
        chk("A_byte3", wr_log[3], 8'hAD);

        // Run B: second echo corrupted
        run_start(2'b00, 1'b0, 1, 1'b1);
        wait_done();
        chk("B_pass", pass_count, 16'd3);
        chk("B_err", err_count, 16'd1);
        chk("B_div_lo", div_lo_log, 8'h15);
        chk("B_div_hi", div_hi_log, 8'h05);

        // Run C: LFSR mode
        run_start(2'b11, 1'b1, -1, 1'b1);
        wait_done();
        chk("C_byte1", wr_log[1], 8'h55);
        chk("C_byte2", wr_log[2], 8'hAB);
        chk("C_div_lo", div_lo_log, 8'hA2);
        chk("C_pass", pass_count, 16'd4);

        // Run D: echo never arrives, every byte times out
        run_start(2'b10, 1'b0, -1, 1'b0);
        wait_done();
        chk("D_err", err_count, 16'd4);
        chk("D_pass", pass_count, 16'd0);
        chk("D_tseen", timeout_seen, 1'b1);
        chk("D_done", done, 1'b1);

        // Reset in WAIT_RDA after one timeout, then a fresh run with a stray start
        run_start(2'b10, 1'b0, -1, 1'b0);
        for (int i = 0; i < 300 && !(state_value == 4'd5 && err_count != 16'd0); i++) @(negedge clk);
        chk("reach_wait_rda_after_timeout", {state_value, err_count}, {4'd5, 16'd1});
        rst = 1'b1;
        #1;
        check_reset_values("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        run_start(2'b01, 1'b0, -1, 1'b1);
        repeat (3) @(negedge clk);
        br_cfg = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("E_pass", pass_count, 16'd4);
        chk("E_err", err_count, 16'd0);
        chk("E_tseen", timeout_seen, 1'b0);
        chk("E_div_lo", div_lo_log, 8'h8A);
        chk("E_div_hi", div_hi_log, 8'h02);
        chk("E_div_writes", div_wr_cnt, 2);

        // Pattern generator: increment wrap
        @(negedge clk);
        pg_load = 1'b1; pg_seed = 8'hFE; pg_mode = 1'b0;
        @(negedge clk);
        pg_load = 1'b0;
        chk("inc_first", pg_out, 8'hFE);
        pg_adv = 1'b1;
        @(negedge clk);
        chk("inc_second", pg_out, 8'hFF);
        @(negedge clk);
        chk("inc_wrap", pg_out, 8'h00);
        pg_adv = 1'b0;

        // Pattern generator: LFSR from a zero seed, full period
        @(negedge clk);
        pg_load = 1'b1; pg_seed = 8'h00; pg_mode = 1'b1;
        @(negedge clk);
        pg_load = 1'b0;
        chk("lfsr_zero_seed", pg_out, 8'h01);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1] = 1'b1; distinct = 1; cur = 8'h01;
        pg_adv = 1'b1;
        for (int i = 1; i < 255; i++) begin
            @(negedge clk);
            cur = m_next(cur, 1'b1);
            chk("lfsr_seq", pg_out, cur);
            if (i == 1) chk("lfsr_2nd", pg_out, 8'h02);
            if (i == 2) chk("lfsr_3rd", pg_out, 8'h04);
            if (!seen[pg_out] && pg_out != 8'h00) distinct++;
            seen[pg_out] = 1'b1;
        end
        @(negedge clk);
        pg_adv = 1'b0;
        chk("lfsr_period", pg_out, 8'h01);
        chk("lfsr_distinct", distinct, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
